// File: rtl/mpt_pkg.sv
// Shared types for the MPT walker check stage: transaction, permission nibble,
// flush handshake encodings and the access-check helper.
package mpt_pkg;

    localparam int unsigned MPT_ID_WIDTH = 4;
    localparam int unsigned MPT_PERM_W   = 4;
    localparam int unsigned MPT_PAGES    = 16;

    typedef enum logic [1:0] {
        MPT_ACC_READ  = 2'd0,
        MPT_ACC_WRITE = 2'd1,
        MPT_ACC_EXEC  = 2'd2
    } mpt_access_e;

    typedef enum logic [1:0] {
        MPT_FAULT_NONE   = 2'd0,
        MPT_FAULT_PERM   = 2'd1,
        MPT_FAULT_RSVD   = 2'd2,
        MPT_FAULT_ACCESS = 2'd3
    } page_format_fault_e;

    typedef enum logic [1:0] {
        MPT_FLUSH_NONE = 2'd0,
        MPT_FLUSH_ALL  = 2'd1,
        MPT_FLUSH_SDID = 2'd2
    } mptw_flush_ctrl_e;

    typedef enum logic [1:0] {
        MPT_FLUSHED_NONE      = 2'd0,
        MPT_FLUSHED_ONGOING   = 2'd1,
        MPT_FLUSHED_COMPLETED = 2'd2
    } mptw_flush_status_e;

    typedef struct packed {
        logic rsvd;
        logic x;
        logic w;
        logic r;
    } mpt_perm_t;

    typedef struct packed {
        logic                                 valid;
        logic [MPT_PAGES*MPT_PERM_W-1:0]      mpte;
        logic [3:0]                           page_idx;
        mpt_access_e                          access;
        page_format_fault_e                   fault;
        logic [MPT_ID_WIDTH-1:0]              id;
    } mptw_transaction_t;

    typedef struct packed {
        logic                    allow;
        page_format_fault_e      fault;
        logic [MPT_ID_WIDTH-1:0] id;
    } mpt_check_resp_t;

    // Walker faults win over everything; a missing entry is a plain permission
    // denial; malformed nibbles (reserved bit, write-without-read) are RSVD.
    function automatic mpt_check_resp_t mpt_check(input mptw_transaction_t txn);
        mpt_perm_t       perm;
        mpt_check_resp_t resp;
        perm       = mpt_perm_t'(txn.mpte[txn.page_idx*MPT_PERM_W +: MPT_PERM_W]);
        resp.id    = txn.id;
        resp.allow = 1'b0;
        resp.fault = MPT_FAULT_NONE;
        if (txn.fault != MPT_FAULT_NONE) begin
            resp.fault = txn.fault;
        end else if (!txn.valid) begin
            resp.fault = MPT_FAULT_PERM;
        end else if (perm.rsvd || (perm.w && !perm.r)) begin
            resp.fault = MPT_FAULT_RSVD;
        end else begin
            resp.allow = ((txn.access == MPT_ACC_READ)  && perm.r) ||
                         ((txn.access == MPT_ACC_WRITE) && perm.w) ||
                         ((txn.access == MPT_ACC_EXEC)  && perm.x);
            if (!resp.allow) begin
                resp.fault = MPT_FAULT_PERM;
            end
        end
        return resp;
    endfunction

endpackage

// File: rtl/mpt_resp_fifo.sv
// Synchronous FIFO of check responses with a synchronous clear.
// DEPTH must be a power of two (pointers wrap naturally).
module mpt_resp_fifo
    import mpt_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                clear_i,
    input  logic                                push_i,
    input  logic [$bits(mpt_check_resp_t)-1:0]  data_i,
    input  logic                                pop_i,
    output logic [$bits(mpt_check_resp_t)-1:0]  data_o,
    output logic                                empty_o,
    output logic                                full_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned DW = $bits(mpt_check_resp_t);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [DW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == FULL_CNT);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mpt_check_stage.sv
// Final MPT walker stage: permission check of the completed walk, response FIFO
// and flush handshake. Optional perf counters under MPT_CHECK_PERF_CNT_EN.
module mpt_check_stage
    import mpt_pkg::*;
#(
    parameter int unsigned PIPELINE_SLAVE_DATA_WIDTH = $bits(mptw_transaction_t),
    parameter int unsigned RESP_FIFO_DEPTH           = 2,
    parameter int unsigned RESP_ID_WIDTH             = 4
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic                                    stage_slave_valid,
    output logic                                    stage_slave_ready,
    input  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]    stage_slave_data,
    input  logic [$bits(mptw_flush_ctrl_e)-1:0]     stage_ctrl_flush,
    output logic [$bits(mptw_flush_status_e)-1:0]   stage_status_flushed,
    output logic                                    resp_valid_o,
    input  logic                                    resp_ready_i,
    output logic                                    resp_allow_o,
    output logic [$bits(page_format_fault_e)-1:0]   resp_fault_o,
    output logic [RESP_ID_WIDTH-1:0]                resp_id_o
`ifdef MPT_CHECK_PERF_CNT_EN
    ,
    output logic [31:0]                             perf_allow_cnt_o,
    output logic [31:0]                             perf_deny_cnt_o
`endif
);

    typedef enum logic [1:0] {
        FL_IDLE  = 2'd0,
        FL_DRAIN = 2'd1,
        FL_DONE  = 2'd2
    } flush_state_e;

    flush_state_e        fl_state;
    mptw_flush_status_e  fl_status;
    logic                flush_req;

    mptw_transaction_t   txn;
    mpt_check_resp_t     chk_resp;
    mpt_check_resp_t     head;
    logic [$bits(mpt_check_resp_t)-1:0] fifo_rdata;
    logic                fifo_empty;
    logic                fifo_full;
    logic                fifo_clear;
    logic                beat;
    logic                pop;

    assign txn       = mptw_transaction_t'(stage_slave_data);
    assign chk_resp  = mpt_check(txn);
    assign flush_req = (stage_ctrl_flush != MPT_FLUSH_NONE);

    assign stage_slave_ready = (fl_state == FL_IDLE) && (!fifo_full || resp_ready_i);
    assign beat              = stage_slave_valid && stage_slave_ready;
    assign fifo_clear        = (fl_state == FL_DRAIN);
    assign pop               = resp_valid_o && resp_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fl_state  <= FL_IDLE;
            fl_status <= MPT_FLUSHED_NONE;
        end else begin
            case (fl_state)
                FL_IDLE: begin
                    if (flush_req) begin
                        fl_state  <= FL_DRAIN;
                        fl_status <= MPT_FLUSHED_ONGOING;
                    end
                end
                // Always exactly one cycle; DONE is visited even if flush dropped here.
                FL_DRAIN: begin
                    fl_state  <= FL_DONE;
                    fl_status <= MPT_FLUSHED_COMPLETED;
                end
                FL_DONE: begin
                    if (!flush_req) begin
                        fl_state  <= FL_IDLE;
                        fl_status <= MPT_FLUSHED_NONE;
                    end
                end
                default: begin
                    fl_state  <= FL_IDLE;
                    fl_status <= MPT_FLUSHED_NONE;
                end
            endcase
        end
    end

    assign stage_status_flushed = fl_status;

    mpt_resp_fifo #(
        .DEPTH (RESP_FIFO_DEPTH)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (fifo_clear),
        .push_i  (beat),
        .data_i  (chk_resp),
        .pop_i   (pop),
        .data_o  (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign head         = mpt_check_resp_t'(fifo_rdata);
    assign resp_valid_o = !fifo_empty && (fl_state == FL_IDLE);
    assign resp_allow_o = resp_valid_o && head.allow;
    assign resp_fault_o = resp_valid_o ? head.fault : MPT_FAULT_NONE;

    logic [RESP_ID_WIDTH-1:0] head_id;

    generate
        if (RESP_ID_WIDTH <= MPT_ID_WIDTH) begin : g_id_trunc
            assign head_id = head.id[RESP_ID_WIDTH-1:0];
        end else begin : g_id_ext
            assign head_id = {{(RESP_ID_WIDTH-MPT_ID_WIDTH){1'b0}}, head.id};
        end
    endgenerate

    assign resp_id_o = resp_valid_o ? head_id : '0;

`ifdef MPT_CHECK_PERF_CNT_EN
    logic [31:0] perf_allow_q;
    logic [31:0] perf_deny_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_allow_q <= '0;
            perf_deny_q  <= '0;
        end else if (fifo_clear) begin
            perf_allow_q <= '0;
            perf_deny_q  <= '0;
        end else if (beat) begin
            if (chk_resp.allow) begin
                if (perf_allow_q != '1) begin
                    perf_allow_q <= perf_allow_q + 32'd1;
                end
            end else begin
                if (perf_deny_q != '1) begin
                    perf_deny_q <= perf_deny_q + 32'd1;
                end
            end
        end
    end

    assign perf_allow_cnt_o = perf_allow_q;
    assign perf_deny_cnt_o  = perf_deny_q;
`endif

endmodule

// File: tb/tb_mpt_check_stage.sv
// Directed bench for mpt_check_stage: permission decode, FIFO backpressure,
// flush sequencing, async reset and (with MPT_CHECK_PERF_CNT_EN) perf counters.
module tb_mpt_check_stage;
    import mpt_pkg::*;

    localparam int unsigned PSDW = $bits(mptw_transaction_t);

    logic             clk_i;
    logic             rst_ni;
    logic             stage_slave_valid;
    logic             stage_slave_ready;
    logic [PSDW-1:0]  stage_slave_data;
    logic [1:0]       stage_ctrl_flush;
    logic [1:0]       stage_status_flushed;
    logic             resp_valid_o;
    logic             resp_ready_i;
    logic             resp_allow_o;
    logic [1:0]       resp_fault_o;
    logic [3:0]       resp_id_o;
`ifdef MPT_CHECK_PERF_CNT_EN
    logic [31:0]      perf_allow_cnt_o;
    logic [31:0]      perf_deny_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    mpt_check_stage #(
        .PIPELINE_SLAVE_DATA_WIDTH (PSDW),
        .RESP_FIFO_DEPTH           (2),
        .RESP_ID_WIDTH             (4)
    ) dut (
        .clk_i                (clk_i),
        .rst_ni               (rst_ni),
        .stage_slave_valid    (stage_slave_valid),
        .stage_slave_ready    (stage_slave_ready),
        .stage_slave_data     (stage_slave_data),
        .stage_ctrl_flush     (stage_ctrl_flush),
        .stage_status_flushed (stage_status_flushed),
        .resp_valid_o         (resp_valid_o),
        .resp_ready_i         (resp_ready_i),
        .resp_allow_o         (resp_allow_o),
        .resp_fault_o         (resp_fault_o),
        .resp_id_o            (resp_id_o)
`ifdef MPT_CHECK_PERF_CNT_EN
        ,
        .perf_allow_cnt_o     (perf_allow_cnt_o),
        .perf_deny_cnt_o      (perf_deny_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic mptw_transaction_t mk(input mpt_access_e acc, input logic [3:0] pg,
                                             input logic [3:0] perm, input logic [3:0] id);
        mptw_transaction_t t;
        t                = '0;
        t.valid          = 1'b1;
        t.access         = acc;
        t.page_idx       = pg;
        t.id             = id;
        t.fault          = MPT_FAULT_NONE;
        t.mpte[pg*4 +: 4] = perm;
        return t;
    endfunction

    task automatic send(input mptw_transaction_t t);
        @(posedge clk_i); #1;
        stage_slave_valid = 1'b1;
        stage_slave_data  = t;
        @(posedge clk_i); #1;
        stage_slave_valid = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic a, input logic [1:0] f, input logic [3:0] id);
        check({tag, ".valid"}, {31'd0, resp_valid_o}, 32'd1);
        check({tag, ".allow"}, {31'd0, resp_allow_o}, {31'd0, a});
        check({tag, ".fault"}, {30'd0, resp_fault_o}, {30'd0, f});
        check({tag, ".id"},    {28'd0, resp_id_o},    {28'd0, id});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mptw_transaction_t t;
        rst_ni            = 1'b0;
        stage_slave_valid = 1'b0;
        stage_slave_data  = '0;
        stage_ctrl_flush  = MPT_FLUSH_NONE;
        resp_ready_i      = 1'b1;

        #12;
        check("rst.valid",  {31'd0, resp_valid_o}, 32'd0);
        check("rst.allow",  {31'd0, resp_allow_o}, 32'd0);
        check("rst.fault",  {30'd0, resp_fault_o}, MPT_FAULT_NONE);
        check("rst.id",     {28'd0, resp_id_o}, 32'd0);
        check("rst.status", {30'd0, stage_status_flushed}, MPT_FLUSHED_NONE);
        check("rst.ready",  {31'd0, stage_slave_ready}, 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Permission decode, one beat at a time, requester always ready
        send(mk(MPT_ACC_READ, 4'd3, 4'b0001, 4'd5));
        expect_resp("t1_read", 1'b1, MPT_FAULT_NONE, 4'd5);
        send(mk(MPT_ACC_WRITE, 4'd0, 4'b0001, 4'd6));
        expect_resp("t2_wr_ronly", 1'b0, MPT_FAULT_PERM, 4'd6);
        send(mk(MPT_ACC_WRITE, 4'd0, 4'b0010, 4'd7));
        expect_resp("t2_w_no_r", 1'b0, MPT_FAULT_RSVD, 4'd7);
        send(mk(MPT_ACC_EXEC, 4'd15, 4'b0101, 4'd8));
        expect_resp("exec_pg15", 1'b1, MPT_FAULT_NONE, 4'd8);
        send(mk(MPT_ACC_READ, 4'd7, 4'b1001, 4'd9));
        expect_resp("rsvd_bit", 1'b0, MPT_FAULT_RSVD, 4'd9);
        send(mk(MPT_ACC_WRITE, 4'd2, 4'b0011, 4'd10));
        expect_resp("write_rw", 1'b1, MPT_FAULT_NONE, 4'd10);
        t = mk(MPT_ACC_READ, 4'd1, 4'b0001, 4'd11);
        t.fault = MPT_FAULT_ACCESS;
        send(t);
        expect_resp("fwd_fault", 1'b0, MPT_FAULT_ACCESS, 4'd11);
        t = mk(MPT_ACC_READ, 4'd4, 4'b0111, 4'd12);
        t.valid = 1'b0;
        send(t);
        expect_resp("no_entry", 1'b0, MPT_FAULT_PERM, 4'd12);
        send(mk(MPT_ACC_EXEC, 4'd5, 4'b0011, 4'd13));
        expect_resp("exec_deny", 1'b0, MPT_FAULT_PERM, 4'd13);
        @(posedge clk_i); #1;
        check("t1.drained", {31'd0, resp_valid_o}, 32'd0);

        // Backpressure: two accepted, third stalls, head stays put
        resp_ready_i = 1'b0;
        @(posedge clk_i); #1;
        stage_slave_valid = 1'b1;
        stage_slave_data  = mk(MPT_ACC_READ, 4'd1, 4'b0001, 4'd1);
        check("t3.rdy0", {31'd0, stage_slave_ready}, 32'd1);
        @(posedge clk_i); #1;
        stage_slave_data  = mk(MPT_ACC_WRITE, 4'd1, 4'b0001, 4'd2);
        check("t3.rdy1", {31'd0, stage_slave_ready}, 32'd1);
        expect_resp("t3.headA", 1'b1, MPT_FAULT_NONE, 4'd1);
        @(posedge clk_i); #1;
        stage_slave_data  = mk(MPT_ACC_EXEC, 4'd1, 4'b0100, 4'd3);
        check("t3.rdy_full", {31'd0, stage_slave_ready}, 32'd0);
        expect_resp("t3.headA2", 1'b1, MPT_FAULT_NONE, 4'd1);
        @(posedge clk_i); #1;
        check("t3.rdy_hold", {31'd0, stage_slave_ready}, 32'd0);
        expect_resp("t3.headA3", 1'b1, MPT_FAULT_NONE, 4'd1);

        // Full FIFO, pop and push in the same cycle
        resp_ready_i = 1'b1;
        #1;
        check("t4.rdy_pp", {31'd0, stage_slave_ready}, 32'd1);
        @(posedge clk_i); #1;
        stage_slave_valid = 1'b0;
        expect_resp("t4.headB", 1'b0, MPT_FAULT_PERM, 4'd2);
        resp_ready_i = 1'b0;
        #1;
        check("t4.still_full", {31'd0, stage_slave_ready}, 32'd0);
        resp_ready_i = 1'b1;
        @(posedge clk_i); #1;
        expect_resp("t4.headC", 1'b1, MPT_FAULT_NONE, 4'd3);
        @(posedge clk_i); #1;
        check("t4.empty", {31'd0, resp_valid_o}, 32'd0);
        check("t4.rdy", {31'd0, stage_slave_ready}, 32'd1);

        // Flush with two queued entries
        resp_ready_i = 1'b0;
        @(posedge clk_i); #1;
        stage_slave_valid = 1'b1;
        stage_slave_data  = mk(MPT_ACC_READ, 4'd8, 4'b0001, 4'd4);
        @(posedge clk_i); #1;
        stage_slave_data  = mk(MPT_ACC_READ, 4'd8, 4'b0000, 4'd6);
        @(posedge clk_i); #1;
        stage_slave_valid = 1'b0;
        expect_resp("t5.headD", 1'b1, MPT_FAULT_NONE, 4'd4);
        check("t5.full", {31'd0, stage_slave_ready}, 32'd0);
        stage_ctrl_flush = MPT_FLUSH_ALL;
        #1;
        check("t5.st_idle", {30'd0, stage_status_flushed}, MPT_FLUSHED_NONE);
        @(posedge clk_i); #1;
        check("t5.st_ongoing", {30'd0, stage_status_flushed}, MPT_FLUSHED_ONGOING);
        check("t5.drain_valid", {31'd0, resp_valid_o}, 32'd0);
        check("t5.drain_rdy", {31'd0, stage_slave_ready}, 32'd0);
        @(posedge clk_i); #1;
        check("t5.st_done", {30'd0, stage_status_flushed}, MPT_FLUSHED_COMPLETED);
        check("t5.done_valid", {31'd0, resp_valid_o}, 32'd0);
        check("t5.done_rdy", {31'd0, stage_slave_ready}, 32'd0);
        stage_slave_valid = 1'b1;
        stage_slave_data  = mk(MPT_ACC_READ, 4'd2, 4'b0001, 4'd14);
        resp_ready_i      = 1'b1;
        @(posedge clk_i); #1;
        check("t5.st_hold", {30'd0, stage_status_flushed}, MPT_FLUSHED_COMPLETED);
        check("t5.ignored", {31'd0, resp_valid_o}, 32'd0);
        stage_slave_valid = 1'b0;
        stage_ctrl_flush  = MPT_FLUSH_NONE;
        @(posedge clk_i); #1;
        check("t5.st_back", {30'd0, stage_status_flushed}, MPT_FLUSHED_NONE);
        check("t5.no_resp", {31'd0, resp_valid_o}, 32'd0);
        check("t5.rdy_back", {31'd0, stage_slave_ready}, 32'd1);

        // Flush dropped during DRAIN still passes through DONE once
        stage_ctrl_flush = MPT_FLUSH_SDID;
        @(posedge clk_i); #1;
        check("t5b.ongoing", {30'd0, stage_status_flushed}, MPT_FLUSHED_ONGOING);
        stage_ctrl_flush = MPT_FLUSH_NONE;
        @(posedge clk_i); #1;
        check("t5b.done", {30'd0, stage_status_flushed}, MPT_FLUSHED_COMPLETED);
        @(posedge clk_i); #1;
        check("t5b.idle", {30'd0, stage_status_flushed}, MPT_FLUSHED_NONE);

        // Async reset with a response pending and a flush in progress
        resp_ready_i = 1'b0;
        send(mk(MPT_ACC_READ, 4'd6, 4'b0001, 4'd9));
        expect_resp("rst.pend", 1'b1, MPT_FAULT_NONE, 4'd9);
        stage_ctrl_flush = MPT_FLUSH_ALL;
        @(posedge clk_i); #1;
        check("rst.mid_flush", {30'd0, stage_status_flushed}, MPT_FLUSHED_ONGOING);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst.status", {30'd0, stage_status_flushed}, MPT_FLUSHED_NONE);
        check("arst.valid", {31'd0, resp_valid_o}, 32'd0);
        check("arst.id", {28'd0, resp_id_o}, 32'd0);
        check("arst.rdy", {31'd0, stage_slave_ready}, 32'd1);
        stage_ctrl_flush = MPT_FLUSH_NONE;
        resp_ready_i     = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        check("arst.stays_empty", {31'd0, resp_valid_o}, 32'd0);

`ifdef MPT_CHECK_PERF_CNT_EN
        check("perf.rst_allow", perf_allow_cnt_o, 32'd0);
        check("perf.rst_deny", perf_deny_cnt_o, 32'd0);
        stage_slave_valid = 1'b1;
        stage_slave_data  = mk(MPT_ACC_READ, 4'd0, 4'b0001, 4'd1);
        @(posedge clk_i); #1;
        stage_slave_data  = mk(MPT_ACC_WRITE, 4'd0, 4'b0001, 4'd2);
        @(posedge clk_i); #1;
        stage_slave_data  = mk(MPT_ACC_EXEC, 4'd9, 4'b0100, 4'd3);
        @(posedge clk_i); #1;
        stage_slave_data  = mk(MPT_ACC_WRITE, 4'd9, 4'b1011, 4'd4);
        @(posedge clk_i); #1;
        stage_slave_data  = mk(MPT_ACC_WRITE, 4'd12, 4'b0011, 4'd5);
        @(posedge clk_i); #1;
        stage_slave_valid = 1'b0;
        check("perf.allow", perf_allow_cnt_o, 32'd3);
        check("perf.deny", perf_deny_cnt_o, 32'd2);
        stage_ctrl_flush = MPT_FLUSH_ALL;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check("perf.flush_allow", perf_allow_cnt_o, 32'd0);
        check("perf.flush_deny", perf_deny_cnt_o, 32'd0);
        stage_ctrl_flush = MPT_FLUSH_NONE;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
